// File: rtl/vx_task_pkg.sv
// Shared definitions for the kernel task dispatcher.
//   - DCR register offsets for the launch registers
//   - task_state_e : dispatcher FSM states
//   - task_desc_t  : one task descriptor as seen by a core (pc, arg, block coordinates)
package vx_task_pkg;

  localparam int unsigned VX_TASK_DIM_W = 16;

  localparam logic [11:0] VX_DCR_TASK_PC     = 12'h010;
  localparam logic [11:0] VX_DCR_TASK_ARG    = 12'h011;
  localparam logic [11:0] VX_DCR_TASK_GRID_X = 12'h012;
  localparam logic [11:0] VX_DCR_TASK_GRID_Y = 12'h013;
  localparam logic [11:0] VX_DCR_TASK_GRID_Z = 12'h014;
  localparam logic [11:0] VX_DCR_TASK_START  = 12'h015;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DISPATCH = 2'd1,
    DRAIN    = 2'd2
  } task_state_e;

  typedef struct packed {
    logic [31:0]              pc;
    logic [31:0]              arg;
    logic [VX_TASK_DIM_W-1:0] bx;
    logic [VX_TASK_DIM_W-1:0] by;
    logic [VX_TASK_DIM_W-1:0] bz;
  } task_desc_t;

endpackage

// File: rtl/vx_grid_counter.sv
// 3-D nested block counter, x fastest, then y, then z.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   clear               : return coordinates to (0,0,0)
//   advance             : step to the next block (wraps at grid limits)
//   grid_x/y/z          : grid dimensions (must be non-zero while counting)
//   bx/by/bz            : current block coordinates
//   last                : current block is (grid_x-1, grid_y-1, grid_z-1)
module vx_grid_counter #(
  parameter int DIM_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 advance,
  input  logic [DIM_WIDTH-1:0] grid_x,
  input  logic [DIM_WIDTH-1:0] grid_y,
  input  logic [DIM_WIDTH-1:0] grid_z,
  output logic [DIM_WIDTH-1:0] bx,
  output logic [DIM_WIDTH-1:0] by,
  output logic [DIM_WIDTH-1:0] bz,
  output logic                 last
);
  logic [DIM_WIDTH-1:0] bx_reg, by_reg, bz_reg;
  logic x_last, y_last, z_last;

  assign x_last = (bx_reg == grid_x - DIM_WIDTH'(1));
  assign y_last = (by_reg == grid_y - DIM_WIDTH'(1));
  assign z_last = (bz_reg == grid_z - DIM_WIDTH'(1));
  assign last   = x_last & y_last & z_last;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      bx_reg <= '0;
      by_reg <= '0;
      bz_reg <= '0;
    end else if (advance) begin
      if (!x_last) begin
        bx_reg <= bx_reg + DIM_WIDTH'(1);
      end else begin
        bx_reg <= '0;
        if (!y_last) begin
          by_reg <= by_reg + DIM_WIDTH'(1);
        end else begin
          by_reg <= '0;
          bz_reg <= z_last ? '0 : bz_reg + DIM_WIDTH'(1);
        end
      end
    end
  end

  assign bx = bx_reg;
  assign by = by_reg;
  assign bz = bz_reg;

endmodule

// File: rtl/vx_task_dispatcher.sv
// Kernel launch front-end: latches PC/ARG/grid from DCR writes, launches on a
// START write, offers one block per handshake to the cores in round-robin
// order and tracks outstanding blocks until all cores report completion.
// Ports:
//   clk, reset                    : clock, synchronous active-high reset
//   dcr_wr_valid/addr/data        : host DCR write bus (ignored while busy)
//   task_valid / task_ready       : one-hot per-core task offer / accept
//   task_pc, task_arg             : latched kernel PC and argument pointer
//   task_bx/by/bz                 : coordinates of the offered block
//   task_done                     : per-core block-completion pulses
//   start                         : one-cycle pulse for an accepted START write
//   busy                          : kernel in flight (state != IDLE)
module vx_task_dispatcher
  import vx_task_pkg::*;
#(
  parameter int NUM_CORES      = 4,
  parameter int DCR_ADDR_WIDTH = 12,
  parameter int DCR_DATA_WIDTH = 32,
  parameter int DIM_WIDTH      = 16,
  parameter int OUTS_WIDTH     = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      dcr_wr_valid,
  input  logic [DCR_ADDR_WIDTH-1:0] dcr_wr_addr,
  input  logic [DCR_DATA_WIDTH-1:0] dcr_wr_data,
  output logic [NUM_CORES-1:0]      task_valid,
  input  logic [NUM_CORES-1:0]      task_ready,
  output logic [31:0]               task_pc,
  output logic [31:0]               task_arg,
  output logic [DIM_WIDTH-1:0]      task_bx,
  output logic [DIM_WIDTH-1:0]      task_by,
  output logic [DIM_WIDTH-1:0]      task_bz,
  input  logic [NUM_CORES-1:0]      task_done,
  output logic                      start,
  output logic                      busy
);
  localparam int PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int CNT_W = $clog2(NUM_CORES + 1);

  logic [31:0]            pc_reg, arg_reg;
  logic [DIM_WIDTH-1:0]   grid_x_reg, grid_y_reg, grid_z_reg;
  task_state_e            state_reg, state_next;
  logic [PTR_W-1:0]       rr_ptr_reg, rr_ptr_next, rr_ptr_inc;
  logic [NUM_CORES-1:0]   task_valid_reg, task_valid_next;
  logic                   start_reg, busy_reg;
  logic [OUTS_WIDTH-1:0]  outstanding_reg, outstanding_next;

  logic wr_en, start_wr, grid_ok, launch, fire, last;
  logic [DIM_WIDTH-1:0] bx, by, bz;

  // Writes are dropped while busy, including START.
  assign wr_en    = dcr_wr_valid & ~busy_reg;
  assign start_wr = wr_en & (dcr_wr_addr == DCR_ADDR_WIDTH'(VX_DCR_TASK_START));
  assign grid_ok  = (grid_x_reg != '0) & (grid_y_reg != '0) & (grid_z_reg != '0);
  assign launch   = start_wr & grid_ok;
  // task_valid is one-hot, so any matching bit is the handshake.
  assign fire     = |(task_valid_reg & task_ready);

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_reg     <= '0;
      arg_reg    <= '0;
      grid_x_reg <= '0;
      grid_y_reg <= '0;
      grid_z_reg <= '0;
    end else if (wr_en) begin
      if (dcr_wr_addr == DCR_ADDR_WIDTH'(VX_DCR_TASK_PC))     pc_reg     <= 32'(dcr_wr_data);
      if (dcr_wr_addr == DCR_ADDR_WIDTH'(VX_DCR_TASK_ARG))    arg_reg    <= 32'(dcr_wr_data);
      if (dcr_wr_addr == DCR_ADDR_WIDTH'(VX_DCR_TASK_GRID_X)) grid_x_reg <= DIM_WIDTH'(dcr_wr_data);
      if (dcr_wr_addr == DCR_ADDR_WIDTH'(VX_DCR_TASK_GRID_Y)) grid_y_reg <= DIM_WIDTH'(dcr_wr_data);
      if (dcr_wr_addr == DCR_ADDR_WIDTH'(VX_DCR_TASK_GRID_Z)) grid_z_reg <= DIM_WIDTH'(dcr_wr_data);
    end
  end

  vx_grid_counter #(
    .DIM_WIDTH (DIM_WIDTH)
  ) grid_counter (
    .clk     (clk),
    .reset   (reset),
    .clear   (launch),
    .advance (fire),
    .grid_x  (grid_x_reg),
    .grid_y  (grid_y_reg),
    .grid_z  (grid_z_reg),
    .bx      (bx),
    .by      (by),
    .bz      (bz),
    .last    (last)
  );

  // Completion count: zero-extend each done bit, then sum.
  logic [CNT_W-1:0] done_bit [NUM_CORES];
  logic [CNT_W-1:0] done_cnt;
  logic [OUTS_WIDTH-1:0] outs_inc, done_ext;
  logic underflow;

  generate
    for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_done
      assign done_bit[gi] = {{(CNT_W-1){1'b0}}, task_done[gi]};
    end
  endgenerate

  always_comb begin
    done_cnt = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      done_cnt = done_cnt + done_bit[i];
    end
    outs_inc         = outstanding_reg + {{(OUTS_WIDTH-1){1'b0}}, fire};
    done_ext         = {{(OUTS_WIDTH-CNT_W){1'b0}}, done_cnt};
    underflow        = (outs_inc < done_ext);
    outstanding_next = underflow ? '0 : outs_inc - done_ext;
  end

  assign rr_ptr_inc = (rr_ptr_reg == PTR_W'(NUM_CORES - 1)) ? '0 : rr_ptr_reg + PTR_W'(1);

  always_comb begin
    state_next      = state_reg;
    rr_ptr_next     = rr_ptr_reg;
    task_valid_next = task_valid_reg;
    if (fire) rr_ptr_next = rr_ptr_inc;
    case (state_reg)
      IDLE: begin
        if (launch) begin
          state_next      = DISPATCH;
          rr_ptr_next     = '0;
          task_valid_next = NUM_CORES'(1);
        end
      end
      DISPATCH: begin
        if (fire) begin
          if (last) begin
            state_next      = DRAIN;
            task_valid_next = '0;
          end else begin
            task_valid_next = NUM_CORES'(1) << rr_ptr_inc;
          end
        end
      end
      DRAIN: begin
        // Leaving on the cycle the final completion arrives keeps busy
        // dropping one cycle after the last task_done pulse.
        if (outstanding_next == '0) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= IDLE;
      rr_ptr_reg      <= '0;
      task_valid_reg  <= '0;
      start_reg       <= 1'b0;
      busy_reg        <= 1'b0;
      outstanding_reg <= '0;
    end else begin
      state_reg       <= state_next;
      rr_ptr_reg      <= rr_ptr_next;
      task_valid_reg  <= task_valid_next;
      start_reg       <= start_wr;
      busy_reg        <= (state_next != IDLE);
      outstanding_reg <= outstanding_next;
    end
  end

`ifndef SYNTHESIS
  // A completion with nothing outstanding means a core misbehaved.
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!underflow);
    end
  end
`endif

  assign task_valid = task_valid_reg;
  assign task_pc    = pc_reg;
  assign task_arg   = arg_reg;
  assign task_bx    = bx;
  assign task_by    = by;
  assign task_bz    = bz;
  assign start      = start_reg;
  assign busy       = busy_reg;

endmodule

// File: tb/tb_vx_task_dispatcher.sv
// Self-checking bench for vx_task_dispatcher: directed scenarios plus random
// launches, compared every cycle against a block-index reference model.
module tb_vx_task_dispatcher;
  import vx_task_pkg::*;

  localparam int NC = 4;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          dcr_wr_valid;
  logic [11:0]   dcr_wr_addr;
  logic [31:0]   dcr_wr_data;
  logic [NC-1:0] task_valid, task_ready, task_done;
  logic [31:0]   task_pc, task_arg;
  logic [DW-1:0] task_bx, task_by, task_bz;
  logic          start, busy;

  always #5 clk = ~clk;

  vx_task_dispatcher #(
    .NUM_CORES(NC), .DCR_ADDR_WIDTH(12), .DCR_DATA_WIDTH(32), .DIM_WIDTH(DW), .OUTS_WIDTH(32)
  ) dut (
    .clk(clk), .reset(reset),
    .dcr_wr_valid(dcr_wr_valid), .dcr_wr_addr(dcr_wr_addr), .dcr_wr_data(dcr_wr_data),
    .task_valid(task_valid), .task_ready(task_ready),
    .task_pc(task_pc), .task_arg(task_arg),
    .task_bx(task_bx), .task_by(task_by), .task_bz(task_bz),
    .task_done(task_done), .start(start), .busy(busy)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference model: phase 0=idle 1=dispatching 2=draining; blocks are a linear
  // index, coordinates derived with division/modulo, core = index mod NC.
  int          ph, blk, total, outs;
  logic        start_m;
  logic [31:0] m_pc, m_arg;
  int          m_gx, m_gy, m_gz;
  int          pending [NC];
  int          ready_pct = 100;
  bit          done_en   = 0;

  task automatic model_update();
    bit fire;
    int dn, nph, nouts, core;
    if (reset) begin
      ph = 0; blk = 0; total = 0; outs = 0; start_m = 0;
      m_pc = 0; m_arg = 0; m_gx = 0; m_gy = 0; m_gz = 0;
      for (int i = 0; i < NC; i++) pending[i] = 0;
      return;
    end
    core = blk % NC;
    fire = (ph == 1) && task_ready[core];
    if (fire) begin
      pending[core]++;
      $display("task core %0d block (%0d,%0d,%0d) pc=0x%08h", core,
               blk % m_gx, (blk / m_gx) % m_gy, blk / (m_gx * m_gy), m_pc);
    end
    dn = $countones(task_done);
    for (int i = 0; i < NC; i++) if (task_done[i]) pending[i]--;
    nouts = outs + int'(fire) - dn;
    nph = ph;
    start_m = 0;
    if (dcr_wr_valid && ph == 0) begin
      if (dcr_wr_addr == VX_DCR_TASK_PC)     m_pc  = dcr_wr_data;
      if (dcr_wr_addr == VX_DCR_TASK_ARG)    m_arg = dcr_wr_data;
      if (dcr_wr_addr == VX_DCR_TASK_GRID_X) m_gx  = int'(dcr_wr_data[15:0]);
      if (dcr_wr_addr == VX_DCR_TASK_GRID_Y) m_gy  = int'(dcr_wr_data[15:0]);
      if (dcr_wr_addr == VX_DCR_TASK_GRID_Z) m_gz  = int'(dcr_wr_data[15:0]);
      if (dcr_wr_addr == VX_DCR_TASK_START) begin
        start_m = 1;
        if (m_gx != 0 && m_gy != 0 && m_gz != 0) begin
          nph = 1; blk = 0; total = m_gx * m_gy * m_gz;
        end
      end
    end
    if (ph == 1 && fire) begin
      blk++;
      if (blk == total) nph = 2;
    end
    if (ph == 2 && nouts == 0) nph = 0;
    ph = nph;
    outs = nouts;
  endtask

  // One clock: compare outputs mid-cycle, then advance the model at the edge.
  task automatic step();
    logic [NC-1:0] ev;
    task_desc_t exp;
    @(negedge clk);
    ev = '0;
    if (ph == 1) ev[blk % NC] = 1'b1;
    check("task_valid", task_valid, ev);
    check("busy", busy, ph != 0);
    check("start", start, start_m);
    check("outstanding", dut.outstanding_reg, outs);
    if (ph == 1) begin
      exp.pc  = m_pc;
      exp.arg = m_arg;
      exp.bx  = 16'(blk % m_gx);
      exp.by  = 16'((blk / m_gx) % m_gy);
      exp.bz  = 16'(blk / (m_gx * m_gy));
      check("task_pc", task_pc, exp.pc);
      check("task_arg", task_arg, exp.arg);
      check("task_bx", task_bx, exp.bx);
      check("task_by", task_by, exp.by);
      check("task_bz", task_bz, exp.bz);
    end
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic rand_inputs();
    for (int i = 0; i < NC; i++) begin
      task_ready[i] = ($urandom_range(99) < ready_pct);
      task_done[i]  = done_en && (pending[i] > 0) && ($urandom_range(2) == 0);
    end
  endtask

  task automatic run(input int n);
    repeat (n) begin
      rand_inputs();
      step();
    end
  endtask

  task automatic dcr(input logic [11:0] addr, input logic [31:0] data);
    dcr_wr_valid = 1'b1;
    dcr_wr_addr  = addr;
    dcr_wr_data  = data;
    rand_inputs();
    step();
    dcr_wr_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int k, pend;
    k = 0;
    done_en = 1;
    if (ready_pct == 0) ready_pct = 50;
    forever begin
      pend = 0;
      for (int i = 0; i < NC; i++) pend += pending[i];
      if ((ph == 0 && pend == 0) || k >= budget) break;
      rand_inputs();
      step();
      k++;
    end
    if (k >= budget) check("idle_timeout", 1, 0);
  endtask

  task automatic set_grid(input int gx, input int gy, input int gz);
    dcr(VX_DCR_TASK_GRID_X, gx);
    dcr(VX_DCR_TASK_GRID_Y, gy);
    dcr(VX_DCR_TASK_GRID_Z, gz);
  endtask

  initial begin
    reset = 1'b1; dcr_wr_valid = 1'b0; dcr_wr_addr = '0; dcr_wr_data = '0;
    task_ready = '0; task_done = '0;
    ph = 0; blk = 0; total = 0; outs = 0; start_m = 0;
    m_pc = 0; m_arg = 0; m_gx = 0; m_gy = 0; m_gz = 0;
    for (int i = 0; i < NC; i++) pending[i] = 0;
    @(posedge clk); #1;
    step();
    check("rst_state", dut.state_reg, IDLE);
    check("rst_rr_ptr", dut.rr_ptr_reg, 0);
    reset = 1'b0;

    // 1: 2x2x1 grid, every core ready
    ready_pct = 100; done_en = 0;
    dcr(VX_DCR_TASK_PC, 32'h8000_0000);
    dcr(VX_DCR_TASK_ARG, 32'h0000_1234);
    set_grid(2, 2, 1);
    dcr(VX_DCR_TASK_START, 0);
    run(4);
    wait_idle(200);

    // 2: 3x1x1 grid, core 1 stalls for 5 cycles
    set_grid(3, 1, 1);
    done_en = 0; ready_pct = 100;
    dcr(VX_DCR_TASK_START, 0);
    run(1);
    task_ready = 4'b1101; task_done = '0;
    repeat (5) step();
    run(2);
    wait_idle(200);

    // 3: zero grid dimension -> start pulse only
    dcr(VX_DCR_TASK_GRID_Y, 0);
    dcr(VX_DCR_TASK_START, 0);
    run(3);

    // 4: writes during DISPATCH are dropped
    dcr(VX_DCR_TASK_GRID_Y, 2);
    ready_pct = 0; done_en = 0;
    dcr(VX_DCR_TASK_START, 0);
    dcr(VX_DCR_TASK_GRID_X, 7);
    dcr(VX_DCR_TASK_START, 0);
    ready_pct = 60;
    wait_idle(300);
    check("grid_x_kept", dut.grid_x_reg, m_gx);
    run(3);

    // 5: fire + done in one cycle, then two dones in one cycle
    set_grid(4, 1, 1);
    ready_pct = 100; done_en = 0;
    dcr(VX_DCR_TASK_START, 0);
    run(2);
    task_ready = '1; task_done = 4'b0001;
    step();
    check("outs_fire_done", dut.outstanding_reg, 2);
    task_ready = '0; task_done = 4'b0110;
    step();
    check("outs_double_done", dut.outstanding_reg, 0);
    task_done = '0;
    ready_pct = 100;
    wait_idle(200);

    // 6: reset after 3 of 8 blocks, then relaunch
    set_grid(8, 1, 1);
    ready_pct = 100; done_en = 0;
    dcr(VX_DCR_TASK_START, 0);
    run(3);
    reset = 1'b1; task_ready = '0; task_done = '0;
    step();
    check("rst_mid_valid", task_valid, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_state", dut.state_reg, IDLE);
    reset = 1'b0;
    set_grid(2, 2, 1);
    dcr(VX_DCR_TASK_START, 0);
    run(1);
    ready_pct = 70;
    wait_idle(200);

    // Random launches
    repeat (8) begin
      done_en = 1;
      ready_pct = $urandom_range(30, 100);
      dcr(VX_DCR_TASK_PC, $urandom);
      dcr(VX_DCR_TASK_ARG, $urandom);
      dcr(12'h3F0, $urandom);
      set_grid($urandom_range(1, 3), $urandom_range(1, 3), $urandom_range(0, 2));
      dcr(VX_DCR_TASK_START, 0);
      wait_idle(400);
      run(2);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/vx_task_dispatcher.md
Name: vx_task_dispatcher

Overview:
Kernel launch front-end between the host DCR write bus and the per-core task inputs of the clusters. Latches kernel PC, argument pointer and a 3-D grid through DCR writes, and starts on a write to the START register. Hands out one block ID per task handshake to the cores in round-robin order, then tracks outstanding blocks until every core reports completion. Drives the device-level kernel busy status.

Parameters:
NUM_CORES, 4, number of task ports (total cores across all clusters)
DCR_ADDR_WIDTH, 12, DCR address width
DCR_DATA_WIDTH, 32, DCR data width
DIM_WIDTH, 16, width of each grid dimension and block coordinate
OUTS_WIDTH, 32, width of the outstanding-block counter

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
dcr_wr_valid  in  1  DCR write strobe
dcr_wr_addr  in  DCR_ADDR_WIDTH  DCR register address
dcr_wr_data  in  DCR_DATA_WIDTH  DCR write data
task_valid  out  NUM_CORES  one-hot task offer, one bit per core
task_ready  in  NUM_CORES  per-core task accept
task_pc  out  32  kernel start PC, broadcast to all cores
task_arg  out  32  kernel argument pointer, broadcast to all cores
task_bx, task_by, task_bz  out  DIM_WIDTH each  block coordinates of the offered task
task_done  in  NUM_CORES  per-core one-cycle block-completion pulse
start  out  1  one-cycle pulse when a launch is accepted
busy  out  1  high from an accepted launch until all blocks have completed

Behaviour:
- Registers, offsets in the package: PC, ARG, GRID_X, GRID_Y, GRID_Z, START. A write is latched when dcr_wr_valid is high and the address matches.
- Grid registers use the low DIM_WIDTH bits of write data. Unmatched addresses are ignored.
- Writes arriving while busy=1 are dropped, including writes to START.
- Reset values: all registers 0, FSM in IDLE, task_valid=0, start=0, busy=0, rr_ptr=0, outstanding=0, block coordinates 0.
- FSM states:
  - IDLE -> DISPATCH on a START write when all grid dimensions are non-zero.
  - DISPATCH -> DRAIN when the last block's handshake fires.
  - DRAIN -> IDLE when outstanding==0.
- START write in IDLE with any grid dimension equal to 0: start pulses, busy stays 0, FSM stays IDLE, no task is offered.
- Launch timing: START write accepted in cycle T gives start=1, busy=1 and task_valid[0]=1 in cycle T+1, with coordinates (0,0,0). busy is registered and equals (state!=IDLE).
- Handshake:
  - task_valid is registered and only the bit for core rr_ptr is set.
  - Once offered, the bit and all data outputs stay stable until task_ready for that core is seen.
  - Fire = task_valid[i] & task_ready[i].
- After a fire, in the next cycle:
  - rr_ptr advances by 1, wrapping from NUM_CORES-1 to 0.
  - Coordinates advance with x fastest, then y, then z; x wraps to 0 at GRID_X-1 and carries into y, and likewise y into z.
  - The new offer is presented, giving a peak rate of 1 block/cycle.
- A stalled core blocks dispatch. There is no skipping to other cores.
- The last-block fire happens at (GRID_X-1, GRID_Y-1, GRID_Z-1). In that cycle task_valid drops to 0 next cycle and the FSM moves to DRAIN.
- outstanding counter:
  - Next value = outstanding + fire − popcount(task_done).
  - Width is OUTS_WIDTH with explicit zero-extension.
  - A fire and done pulses in the same cycle combine arithmetically.
- task_done while outstanding is 0: the counter saturates at 0 and a simulation-only assertion fires.
- A DRAIN->IDLE transition and a new START write in the same cycle: the START is dropped, because busy was still 1.
- Reset mid-operation returns all state to reset values next cycle. Offered tasks are withdrawn and in-flight completions are forgotten.
- task_pc and task_arg always drive the latched registers.

Decomposition:
- Package vx_task_pkg holds:
  - DCR offsets VX_DCR_TASK_PC, _ARG, _GRID_X, _GRID_Y, _GRID_Z, _START;
  - the state enum task_state_e {IDLE, DISPATCH, DRAIN};
  - the packed struct task_desc_t {pc, arg, bx, by, bz}.
- One sub-module, vx_grid_counter: a 3-D nested counter with clear, advance, grid inputs, coordinate outputs and a last flag.

Test Plan:
1. Grid 2x2x1, PC=0x80000000, all task_ready=1 -> four consecutive fires to cores 0,1,2,3 with coordinates (0,0,0),(1,0,0),(0,1,0),(1,1,0); busy falls 1 cycle after the 4th task_done.
2. Grid 3x1x1, task_ready[1]=0 for 5 cycles -> the core-1 offer holds (1,0,0) stable for 5 cycles; core 2 gets (2,0,0) only after the core-1 fire.
3. GRID_Y=0, START write -> start pulses once, busy stays 0, task_valid stays 0.
4. Write GRID_X=7 and START during DISPATCH -> both ignored; after return to IDLE the registers read back the old grid and no relaunch occurs.
5. Fire and a task_done pulse on the same cycle with outstanding=2 -> outstanding stays 2; two done pulses in one cycle -> decrement by 2.
6. Assert reset during DISPATCH after 3 of 8 blocks -> next cycle task_valid=0, busy=0, state IDLE; a relaunch restarts from (0,0,0) on core 0.
